inst_prefetch_buffer: RTL and testbench

Instruction prefetch buffer between the instruction memory port and the IF stage of the 5-stage RV32 pipeline. It runs ahead on sequential PCs, keeps up to DEPTH fetched {pc, inst} pairs queued, and hands them to IF through a valid/ready handshake. On a taken branch or jump it flushes its queue and silently discards any memory responses still in flight.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/sync_fifo.sv | 82 ++++++++
 rtl/inst_prefetch_buffer.sv | 133 +++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Purpose: shared RV32 fetch-path types and constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: generic synchronous FIFO with push/pop/flush and occupancy count.
// Latency: a push is visible at pop_data on the next cycle (registered, no bypass).
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_data     write one entry
//   pop                 drop the head entry
//   flush               empty the FIFO this cycle
//   pop_data            head entry (undefined while empty)
//   count, full, empty  occupancy status
module sync_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [63:0],
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Purpose: sequential instruction prefetcher feeding IF, flushing on redirect.
// Latency: response-to-fetch 1 cycle; redirect-to-new-instruction >= 3 cycles.
// Backpressure: requests throttled so queued + outstanding never exceeds DEPTH.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req_valid/_addr/_ready     fetch request to instruction memory
//   imem_rsp_valid/_data            in-order instruction responses
//   redirect, redirect_pc           taken branch/jump from IF
//   fetch_valid/_pc/_inst/_ready    queue head handshake towards IF
module inst_prefetch_buffer
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_inst,
    input  logic            fetch_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_cnt_q, discard_cnt_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_wr;

    logic [CW:0]     credit_used;
    logic [XLEN-1:0] target_pc;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            unused_rpc_bits;

    assign target_pc       = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_rpc_bits = ^redirect_pc[1:0];

    // Reserving a queue slot for every in-flight request means a response
    // always has somewhere to land.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req_valid = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = req_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop = redirect || (discard_cnt_q != '0);
    assign push     = rsp_fire && !rsp_drop && !fifo_full;
    assign pop      = fetch_valid && fetch_ready && !redirect;

    assign fifo_wr.pc   = rsp_pc_q;
    assign fifo_wr.inst = imem_rsp_data;

    always_comb begin
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_cnt_d = discard_cnt_q;

        case ({req_fire, rsp_fire})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect) begin
            req_pc_d = target_pc;
            rsp_pc_d = target_pc;
            // Everything still in flight belongs to the old path, except a
            // response returning this very cycle, which is dropped right here.
            discard_cnt_d = outstanding_q - (rsp_fire ? CW'(1) : CW'(0));
        end else begin
            if (req_fire) req_pc_d = req_pc_q + 32'd4;
            if (push)     rsp_pc_d = rsp_pc_q + 32'd4;
            if (rsp_fire && (discard_cnt_q != '0)) discard_cnt_d = discard_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_cnt_q <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_wr),
        .pop       (pop),
        .flush     (redirect),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // While empty, fetch_pc shows the PC the queue expects next.
    assign fetch_valid = !fifo_empty;
    assign fetch_pc    = fifo_empty ? rsp_pc_q : fifo_head.pc;
    assign fetch_inst  = fifo_empty ? NOP_INST : fifo_head.inst;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Purpose: self-checking bench for inst_prefetch_buffer with a reference fetch model.
// Latency: memory model returns responses in order, lat cycles or more after acceptance.
// Backpressure: fetch_ready and imem_req_ready driven by directed steps or at random.
module tb_inst_prefetch_buffer;
    import riscv_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        fetch_ready = 1'b0;

    inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_inst     (fetch_inst),
        .fetch_ready    (fetch_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        memq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          stall_mode = 1'b0;
    logic        fr = 1'b1, rr = 1'b1, rd = 1'b0;
    logic [31:0] rd_pc = 32'h0;
    logic        s_req_vld, s_fv;
    logic [31:0] s_req_addr, s_fpc, s_finst;
    logic [31:0] exp_pc, exp_req;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc, prev_inst;
    bit          rsp_drv;
    int          n_req_fire = 0, n_fetch_fire = 0;
    int          r_cyc;
    bit          found;

    // Instruction memory contents: an address hash, so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample at negedge, update the model after the edge.
    // The model is the architectural fetch stream: consecutive PCs from the last
    // reset/redirect target, each paired with mem_word(pc).
    task automatic cycle();
        fetch_ready    = fr;
        imem_req_ready = rr;
        redirect       = rd;
        redirect_pc    = rd_pc;
        rsp_drv        = 1'b0;
        if (memq.size() > 0) begin
            if (memq[0].due <= cyc && (!stall_mode || $urandom_range(3) != 0)) rsp_drv = 1'b1;
        end
        imem_rsp_valid = rsp_drv;
        imem_rsp_data  = 32'h0;
        if (rsp_drv) imem_rsp_data = mem_word(memq[0].addr);

        @(negedge clk);
        s_req_vld  = imem_req_valid;
        s_req_addr = imem_req_addr;
        s_fv       = fetch_valid;
        s_fpc      = fetch_pc;
        s_finst    = fetch_inst;

        if (prev_hold) begin
            chk("hold_vld", 32'(s_fv), 32'd1);
            chk("hold_pc", s_fpc, prev_pc);
            chk("hold_inst", s_finst, prev_inst);
        end
        if (rd) chk("redir_no_req", 32'(s_req_vld), 32'd0);
        if (s_req_vld) begin
            chk("req_addr", s_req_addr, exp_req);
            chk("req_credit", 32'(memq.size() < DEPTH), 32'd1);
        end
        if (!s_fv) chk("empty_nop", s_finst, NOP_INST);
        if (s_fv && fr && !rd) begin
            chk("fetch_pc", s_fpc, exp_pc);
            chk("fetch_inst", s_finst, mem_word(exp_pc));
        end
        prev_hold = s_fv && !fr && !rd;
        prev_pc   = s_fpc;
        prev_inst = s_finst;

        @(posedge clk);
        #1;
        if (s_req_vld && rr) begin
            memq.push_back('{s_req_addr, cyc + lat});
            exp_req = exp_req + 32'd4;
            n_req_fire++;
        end
        if (rsp_drv) void'(memq.pop_front());
        if (s_fv && fr && !rd) begin
            exp_pc = exp_pc + 32'd4;
            n_fetch_fire++;
        end
        if (rd) begin
            exp_pc  = {rd_pc[31:2], 2'b00};
            exp_req = {rd_pc[31:2], 2'b00};
        end
        cyc++;
    endtask

    // Reset for one edge; the memory shares reset, so its pipeline empties too.
    task automatic do_reset();
        reset          = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        fetch_ready    = 1'b0;
        imem_req_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_vld", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_fetch_vld", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_pc", fetch_pc, RESET_PC);
        chk("rst_fetch_inst", fetch_inst, NOP_INST);
        memq.delete();
        @(posedge clk);
        #1;
        reset        = 1'b0;
        cyc          = 1;
        exp_pc       = RESET_PC;
        exp_req      = RESET_PC;
        prev_hold    = 1'b0;
        n_req_fire   = 0;
        n_fetch_fire = 0;
        rd           = 1'b0;
    endtask

    initial begin
        // Streaming: 1-cycle memory, everything ready.
        fr = 1'b1; rr = 1'b1; lat = 1; stall_mode = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (cyc - 1 <= 3) begin
                chk("t1_req_vld", 32'(s_req_vld), 32'd1);
                chk("t1_req_addr", s_req_addr, 32'((cyc - 2) * 4));
            end
            chk("t1_fetch_vld", 32'(s_fv), 32'(cyc - 1 >= 3));
            if (cyc - 1 >= 3) chk("t1_fetch_pc", s_fpc, 32'((cyc - 4) * 4));
        end

        // IF stalled: credit limit caps requests at DEPTH.
        fr = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) cycle();
        chk("t2_num_req", 32'(n_req_fire), 32'(DEPTH));
        chk("t2_req_vld_idle", 32'(s_req_vld), 32'd0);
        chk("t2_fetch_vld", 32'(s_fv), 32'd1);
        chk("t2_fetch_pc", s_fpc, 32'h0);

        // 3-cycle memory, redirect with 3 requests in flight.
        fr = 1'b1; lat = 3;
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        chk("t3_outstanding", 32'(memq.size()), 32'd3);
        r_cyc = cyc;
        rd = 1'b1; rd_pc = 32'h0000_0100;
        cycle();
        rd = 1'b0;
        cycle();
        chk("t3_req_vld", 32'(s_req_vld), 32'd1);
        chk("t3_req_addr", s_req_addr, 32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_fv) found = 1'b1;
        end
        chk("t3_found", 32'(found), 32'd1);
        chk("t3_first_pc", s_fpc, 32'h0000_0100);
        chk("t3_first_inst", s_finst, mem_word(32'h0000_0100));
        chk("t3_latency", 32'((cyc - 1 - r_cyc) >= 3), 32'd1);

        // Redirect coinciding with a response and a pop (2-cycle memory).
        lat = 2;
        do_reset();
        for (int i = 0; i < 6; i++) cycle();
        chk("t4_pre_vld", 32'(s_fv), 32'd1);
        rd = 1'b1; rd_pc = 32'h0000_0203;
        cycle();
        rd = 1'b0;
        chk("t4_no_req", 32'(s_req_vld), 32'd0);
        chk("t4_discard", 32'(dut.discard_cnt_q), 32'(memq.size()));
        cycle();
        chk("t4_empty", 32'(s_fv), 32'd0);
        for (int i = 0; i < 8; i++) cycle();
        chk("t4_progress", 32'(n_fetch_fire > 0), 32'd1);

        // Reset mid-operation. With DEPTH=4 the credit rule caps queued plus
        // outstanding at 4, so this is 3 queued and 1 in flight.
        fr = 1'b0; lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_pre_out", 32'(memq.size()), 32'd1);
        do_reset();

        // Address wrap at the top of the address space.
        fr = 1'b1;
        rd = 1'b1; rd_pc = 32'hFFFF_FFF8;
        cycle();
        rd = 1'b0;
        cycle();
        chk("t6_addr0", s_req_addr, 32'hFFFF_FFF8);
        cycle();
        chk("t6_addr1", s_req_addr, 32'hFFFF_FFFC);
        cycle();
        chk("t6_addr_wrap", s_req_addr, 32'h0000_0000);
        for (int i = 0; i < 6; i++) cycle();
        chk("t6_fetch_wrapped", 32'(n_fetch_fire >= 4), 32'd1);

        // Randomized traffic against the reference fetch stream.
        do_reset();
        stall_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            fr    = ($urandom_range(3) != 0);
            rr    = ($urandom_range(3) != 0);
            rd    = ($urandom_range(19) == 0);
            rd_pc = $urandom();
            lat   = 1 + int'($urandom_range(3));
            cycle();
        end
        rd = 1'b0;
        chk("t7_progress", 32'(n_fetch_fire > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
